// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage types and constants.
// Y86 icodes, status codes and the F/D bundle.
package fetch_stage_pkg;

  localparam int DATA_WID = 32;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVL = 4'h2;
  localparam logic [3:0] I_IRMOVL = 4'h3;
  localparam logic [3:0] I_RMMOVL = 4'h4;
  localparam logic [3:0] I_MRMOVL = 4'h5;
  localparam logic [3:0] I_OPL    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHL  = 4'hA;
  localparam logic [3:0] I_POPL   = 4'hB;

  localparam logic [3:0] REG_NONE = 4'hF;

  typedef enum logic [3:0] {
    S_BUB = 4'd0,
    S_AOK = 4'd1,
    S_HLT = 4'd2,
    S_ADR = 4'd3,
    S_INS = 4'd4
  } stat_e;

  typedef struct packed {
    stat_e                stat;
    logic [3:0]           icode;
    logic [3:0]           ifun;
    logic [3:0]           ra;
    logic [3:0]           rb;
    logic [DATA_WID-1:0]  valc;
    logic [DATA_WID-1:0]  valp;
  } fd_t;

  localparam fd_t FD_BUBBLE = '{
    stat:  S_BUB,
    icode: I_NOP,
    ifun:  4'h0,
    ra:    REG_NONE,
    rb:    REG_NONE,
    valc:  '0,
    valp:  '0
  };

endpackage

// File: rtl/fetch_stage_instr_split.sv
// Instruction splitter for the fetch stage.
// Breaks the 6-byte window into Y86 fields.
module fetch_stage_instr_split
  import fetch_stage_pkg::*;
(
  input  logic [47:0]         i_bytes,
  input  logic                i_err,
  output logic [3:0]          o_icode,
  output logic [3:0]          o_ifun,
  output logic [3:0]          o_ra,
  output logic [3:0]          o_rb,
  output logic [DATA_WID-1:0] o_valc,
  output logic [2:0]          o_len,
  output logic                o_need_regids,
  output logic                o_need_valc,
  output logic                o_instr_valid
);

  logic w_len2;
  logic w_len5;
  logic w_len6;

  // Opcode byte, replaced by a NOP on a fetch error
  always_comb begin
    o_icode = i_bytes[7:4];
    o_ifun  = i_bytes[3:0];
    if (i_err) begin
      o_icode = I_NOP;
      o_ifun  = 4'h0;
    end
  end

  assign w_len2 = (o_icode == I_RRMOVL)
               || (o_icode == I_OPL)
               || (o_icode == I_PUSHL)
               || (o_icode == I_POPL);

  assign w_len5 = (o_icode == I_JXX)
               || (o_icode == I_CALL);

  assign w_len6 = (o_icode == I_IRMOVL)
               || (o_icode == I_RMMOVL)
               || (o_icode == I_MRMOVL);

  assign o_instr_valid = (o_icode <= I_POPL);

  // Length class decode; invalid codes fall into 1 byte
  always_comb begin
    o_len         = 3'd1;
    o_need_regids = 1'b0;
    o_need_valc   = 1'b0;
    unique case (1'b1)
      w_len2: begin
        o_len         = 3'd2;
        o_need_regids = 1'b1;
      end
      w_len5: begin
        o_len       = 3'd5;
        o_need_valc = 1'b1;
      end
      w_len6: begin
        o_len         = 3'd6;
        o_need_regids = 1'b1;
        o_need_valc   = 1'b1;
      end
      default: o_len = 3'd1;
    endcase
  end

  // Register byte and little-endian constant
  always_comb begin
    o_ra   = REG_NONE;
    o_rb   = REG_NONE;
    o_valc = '0;
    if (o_need_regids) begin
      o_ra   = i_bytes[15:12];
      o_rb   = i_bytes[11:8];
      o_valc = i_bytes[47:16];
    end else if (o_need_valc) begin
      o_valc = i_bytes[39:8];
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Y86 pipelined instruction fetch stage.
// PC select, predicted-PC and F/D register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DATA_WID = fetch_stage_pkg::DATA_WID
) (
  input  logic                CLK,
  input  logic                RST_N,
  output logic [DATA_WID-1:0] imem_addr,
  input  logic [47:0]         imem_data,
  input  logic                imem_error,
  input  logic                F_stall,
  input  logic                D_stall,
  input  logic                D_bubble,
  input  logic [3:0]          M_icode,
  input  logic                M_Cnd,
  input  logic [DATA_WID-1:0] M_valA,
  input  logic [3:0]          W_icode,
  input  logic [DATA_WID-1:0] W_valM,
  output logic [3:0]          D_stat,
  output logic [3:0]          D_icode,
  output logic [3:0]          D_ifun,
  output logic [3:0]          D_rA,
  output logic [3:0]          D_rB,
  output logic [DATA_WID-1:0] D_valC,
  output logic [DATA_WID-1:0] D_valP
);

  import fetch_stage_pkg::*;

  logic [DATA_WID-1:0] r_pred;
  fd_t                 r_fd;

  logic                w_mispred;
  logic                w_ret;
  logic [DATA_WID-1:0] w_fpc;
  logic [3:0]          w_icode;
  logic [3:0]          w_ifun;
  logic [3:0]          w_ra;
  logic [3:0]          w_rb;
  logic [DATA_WID-1:0] w_valc;
  logic [2:0]          w_len;
  logic                w_need_regids;
  logic                w_need_valc;
  logic                w_valid;
  logic [DATA_WID-1:0] w_valp;
  logic                w_jc;
  stat_e               w_stat;
  logic [DATA_WID-1:0] w_pred_nxt;
  fd_t                 w_fd;

  assign w_mispred = (M_icode == I_JXX) && !M_Cnd;
  assign w_ret     = (W_icode == I_RET);

  // Fetch PC: mispredict fix beats return beats prediction
  always_comb begin
    w_fpc = r_pred;
    if (w_mispred) begin
      w_fpc = M_valA;
    end else if (w_ret) begin
      w_fpc = W_valM;
    end
  end

  assign imem_addr = w_fpc;

  fetch_stage_instr_split u_instr_split (
    .i_bytes       (imem_data),
    .i_err         (imem_error),
    .o_icode       (w_icode),
    .o_ifun        (w_ifun),
    .o_ra          (w_ra),
    .o_rb          (w_rb),
    .o_valc        (w_valc),
    .o_len         (w_len),
    .o_need_regids (w_need_regids),
    .o_need_valc   (w_need_valc),
    .o_instr_valid (w_valid)
  );

  assign w_valp = w_fpc + DATA_WID'(w_len);
  assign w_jc   = w_need_valc && !w_need_regids;

  // Fetch status in priority order
  always_comb begin
    w_stat = S_AOK;
    if (imem_error) begin
      w_stat = S_ADR;
    end else if (!w_valid) begin
      w_stat = S_INS;
    end else if (w_icode == I_HALT) begin
      w_stat = S_HLT;
    end
  end

  // Next prediction; faulting fetches park on f_pc
  always_comb begin
    w_pred_nxt = w_valp;
    if (w_stat != S_AOK) begin
      w_pred_nxt = w_fpc;
    end else if (w_jc) begin
      w_pred_nxt = w_valc;
    end
  end

  // Assemble the bundle headed for decode
  always_comb begin
    w_fd       = FD_BUBBLE;
    w_fd.stat  = w_stat;
    w_fd.icode = w_icode;
    w_fd.ifun  = w_ifun;
    w_fd.ra    = w_ra;
    w_fd.rb    = w_rb;
    w_fd.valc  = w_valc;
    w_fd.valp  = w_valp;
  end

  // Predicted-PC register, frozen by F_stall
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pred <= RESET_PC;
    end else if (!F_stall) begin
      r_pred <= w_pred_nxt;
    end
  end

  // F/D register: stall holds, bubble clears
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_fd <= FD_BUBBLE;
    end else if (!D_stall) begin
      if (D_bubble) begin
        r_fd <= FD_BUBBLE;
      end else begin
        r_fd <= w_fd;
      end
    end
  end

  assign D_stat  = r_fd.stat;
  assign D_icode = r_fd.icode;
  assign D_ifun  = r_fd.ifun;
  assign D_rA    = r_fd.ra;
  assign D_rB    = r_fd.rb;
  assign D_valC  = r_fd.valc;
  assign D_valP  = r_fd.valp;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage.
// Directed steps then random traffic vs a model.
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic [31:0] imem_addr;
  logic [47:0] imem_data = '0;
  logic        imem_error = 1'b0;
  logic        F_stall = 1'b0;
  logic        D_stall = 1'b0;
  logic        D_bubble = 1'b0;
  logic [3:0]  M_icode = 4'h0;
  logic        M_Cnd = 1'b0;
  logic [31:0] M_valA = '0;
  logic [3:0]  W_icode = 4'h0;
  logic [31:0] W_valM = '0;
  logic [3:0]  D_stat, D_icode, D_ifun, D_rA, D_rB;
  logic [31:0] D_valC, D_valP;

  fetch_stage #(.RESET_PC(32'h100)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .imem_error(imem_error),
    .F_stall(F_stall), .D_stall(D_stall),
    .D_bubble(D_bubble),
    .M_icode(M_icode), .M_Cnd(M_Cnd),
    .M_valA(M_valA),
    .W_icode(W_icode), .W_valM(W_valM),
    .D_stat(D_stat), .D_icode(D_icode),
    .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
    .D_valC(D_valC), .D_valP(D_valP)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0]  stat, icode, ifun, ra, rb;
    logic [31:0] valc, valp;
  } dfd_t;

  localparam dfd_t BUB = '{4'd0, 4'd1, 4'd0, 4'hF, 4'hF, 32'd0, 32'd0};
  localparam logic [47:0] IRMOVL = 48'h00_00_00_04_F2_30;
  localparam logic [47:0] JMP80  = 48'h00_00_00_00_80_70;
  localparam logic [47:0] NOP    = 48'h00_00_00_00_00_10;

  int unsigned LEN [16] = '{1, 1, 2, 6, 6, 6, 2, 5, 5, 1, 2, 2, 1, 1, 1, 1};

  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] m_pred;
  dfd_t        m_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic void fmodel(input logic [47:0] d, input logic e,
                                 input logic [31:0] pc,
                                 output dfd_t f, output logic [31:0] np);
    logic [7:0]  b [6];
    int unsigned n;
    for (int i = 0; i < 6; i++) b[i] = d[8*i +: 8];
    f.icode = e ? 4'h1 : b[0][7:4];
    f.ifun  = e ? 4'h0 : b[0][3:0];
    n = LEN[f.icode];
    f.ra = 4'hF;
    f.rb = 4'hF;
    f.valc = 32'd0;
    if (n == 2 || n == 6) begin
      f.ra = b[1][7:4];
      f.rb = b[1][3:0];
      f.valc = {b[5], b[4], b[3], b[2]};
    end else if (f.icode == 4'h7 || f.icode == 4'h8) begin
      f.valc = {b[4], b[3], b[2], b[1]};
    end
    f.valp = pc + n;
    if (e) f.stat = 4'd3;
    else if (f.icode > 4'hB) f.stat = 4'd4;
    else if (f.icode == 4'h0) f.stat = 4'd2;
    else f.stat = 4'd1;
    if (f.stat != 4'd1) np = pc;
    else if (f.icode == 4'h7 || f.icode == 4'h8) np = f.valc;
    else np = f.valp;
  endfunction

  function automatic logic [31:0] model_fpc();
    if (M_icode == 4'h7 && !M_Cnd) return M_valA;
    if (W_icode == 4'h9) return W_valM;
    return m_pred;
  endfunction

  task automatic model_reset();
    m_pred = 32'h100;
    m_d = BUB;
  endtask

  task automatic chk_d();
    chk("D_stat", {28'd0, D_stat}, {28'd0, m_d.stat});
    chk("D_icode", {28'd0, D_icode}, {28'd0, m_d.icode});
    chk("D_ifun", {28'd0, D_ifun}, {28'd0, m_d.ifun});
    if (m_d.stat != 4'd4) begin
      chk("D_rA", {28'd0, D_rA}, {28'd0, m_d.ra});
      chk("D_rB", {28'd0, D_rB}, {28'd0, m_d.rb});
      chk("D_valC", D_valC, m_d.valc);
      chk("D_valP", D_valP, m_d.valp);
    end
  endtask

  task automatic cyc();
    logic [31:0] fpc, np;
    dfd_t        f;
    #1;
    fpc = model_fpc();
    chk("imem_addr", imem_addr, fpc);
    fmodel(imem_data, imem_error, fpc, f, np);
    @(posedge CLK);
    if (!F_stall) m_pred = np;
    if (!D_stall) m_d = D_bubble ? BUB : f;
    #1;
    chk_d();
    @(negedge CLK);
  endtask

  initial begin
    logic [63:0] rnd;
    logic [3:0]  ic;

    #7 RST_N = 1'b0;
    model_reset();
    #1;
    chk("rst_addr", imem_addr, 32'h100);
    chk("rst_stat", {28'd0, D_stat}, 32'd0);
    chk_d();
    @(negedge CLK);
    RST_N = 1'b1;
    imem_data = IRMOVL;
    cyc();
    chk("irm_icode", {28'd0, D_icode}, 32'd3);
    chk("irm_rB", {28'd0, D_rB}, 32'd2);
    chk("irm_valC", D_valC, 32'd4);
    chk("irm_valP", D_valP, 32'h106);

    W_icode = 4'h9; W_valM = 32'h20;
    imem_data = JMP80;
    cyc();
    chk("jmp_valP", D_valP, 32'h25);
    W_icode = 4'h0;
    imem_data = NOP;
    #1 chk("jmp_pred", imem_addr, 32'h80);
    M_icode = 4'h7; M_Cnd = 1'b0; M_valA = 32'h25;
    #1 chk("jmp_fix", imem_addr, 32'h25);
    cyc();

    M_icode = 4'h0;
    W_icode = 4'h9; W_valM = 32'h44;
    #1 chk("ret_only", imem_addr, 32'h44);
    M_icode = 4'h7; M_valA = 32'h30;
    #1 chk("ret_and_mis", imem_addr, 32'h30);
    cyc();
    M_icode = 4'h0; W_icode = 4'h0;

    imem_data = IRMOVL;
    cyc();
    chk("pre_stall_valP", D_valP, 32'h37);
    F_stall = 1'b1; D_stall = 1'b1;
    imem_data = NOP;
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("stall_addr", imem_addr, 32'h37);
      chk("stall_icode", {28'd0, D_icode}, 32'd3);
    end
    F_stall = 1'b0; D_stall = 1'b0; D_bubble = 1'b1;
    cyc();
    chk("bub_stat", {28'd0, D_stat}, 32'd0);
    chk("bub_icode", {28'd0, D_icode}, 32'd1);
    D_bubble = 1'b0;
    imem_data = IRMOVL;
    cyc();
    D_stall = 1'b1; D_bubble = 1'b1;
    imem_data = NOP;
    cyc();
    chk("stbub_icode", {28'd0, D_icode}, 32'd3);
    chk("stbub_valP", D_valP, 32'h3E);
    D_stall = 1'b0; D_bubble = 1'b0;

    imem_error = 1'b1;
    cyc();
    chk("adr_stat", {28'd0, D_stat}, 32'd3);
    chk("adr_icode", {28'd0, D_icode}, 32'd1);
    imem_error = 1'b0;
    #1 chk("adr_hold", imem_addr, 32'h3F);
    cyc();
    imem_data = 48'h0000_0000_00C0;
    cyc();
    chk("ins_stat", {28'd0, D_stat}, 32'd4);
    imem_data = 48'h0000_0000_0000;
    #1 chk("ins_hold", imem_addr, 32'h40);
    cyc();
    chk("hlt_stat", {28'd0, D_stat}, 32'd2);

    W_icode = 4'h9; W_valM = 32'hFFFF_FFFE;
    imem_data = IRMOVL;
    cyc();
    chk("wrap_valP", D_valP, 32'h4);
    W_icode = 4'h0;

    F_stall = 1'b1; D_stall = 1'b1; D_bubble = 1'b1;
    #2 RST_N = 1'b0;
    model_reset();
    #1;
    chk("rst2_addr", imem_addr, 32'h100);
    chk("rst2_stat", {28'd0, D_stat}, 32'd0);
    chk_d();
    @(negedge CLK);
    RST_N = 1'b1;
    F_stall = 1'b0; D_stall = 1'b0; D_bubble = 1'b0;
    imem_data = IRMOVL;
    cyc();

    for (int i = 0; i < 400; i++) begin
      rnd = {$urandom(), $urandom()};
      if ($urandom_range(0, 99) < 5) ic = 4'($urandom_range(12, 15));
      else ic = 4'($urandom_range(0, 11));
      imem_data = {rnd[47:8], ic, rnd[3:0]};
      imem_error = ($urandom_range(0, 99) < 5);
      D_stall = ($urandom_range(0, 99) < 20);
      F_stall = D_stall ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0);
      D_bubble = ($urandom_range(0, 99) < 15);
      M_icode = ($urandom_range(0, 99) < 15) ? 4'h7 : 4'($urandom_range(0, 6));
      M_Cnd = $urandom_range(0, 1) == 1;
      M_valA = $urandom();
      W_icode = ($urandom_range(0, 99) < 10) ? 4'h9 : 4'($urandom_range(0, 8));
      W_valM = $urandom();
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage for the pipelined Y86 datapath. It sits directly upstream of instruction decode and drives instruction memory. It owns the predicted-PC register, selects the fetch PC (predicted, mispredict-corrected, or return address), splits and validates the instruction bytes, and holds the F/D pipeline register under stall and bubble control from the hazard unit.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset
- DATA_WID, 32, datapath width; fixed by the shared header

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- RST_N  in  1  asynchronous, active-low reset
- imem_addr  out  32  byte address of the current fetch (f_pc)
- imem_data  in  48  six bytes starting at imem_addr; byte 0 is imem_data[7:0]; combinational read
- imem_error  in  1  imem_addr is out of range
- F_stall  in  1  hold the predicted-PC register
- D_stall  in  1  hold the F/D register
- D_bubble  in  1  load a bubble into the F/D register
- M_icode  in  4  icode currently in memory stage
- M_Cnd  in  1  branch condition of that instruction
- M_valA  in  32  fall-through address carried by a jXX
- W_icode  in  4  icode currently in writeback
- W_valM  in  32  return address popped by ret
- D_stat, D_icode, D_ifun, D_rA, D_rB  out  4 each  registered decode inputs
- D_valC, D_valP  out  32 each  registered constant and next-sequential PC

## Operation
- f_pc select, in priority order:
  - M_icode==JXX && !M_Cnd: use M_valA.
  - W_icode==RET: use W_valM.
  - Otherwise: use F_predPC.
  - imem_addr = f_pc.
- Split the instruction:
  - icode = byte0[7:4], ifun = byte0[3:0].
  - When imem_error is set, force icode=NOP and ifun=0.
- Instruction valid: icode is 0x0–0xB.
- Lengths:
  - HALT, NOP, RET: 1 byte.
  - RRMOVL/CMOV, OPL, PUSHL, POPL: 2 bytes.
  - JXX, CALL: 5 bytes.
  - IRMOVL, RMMOVL, MRMOVL: 6 bytes.
- Register byte: when it is present, rA = byte1[7:4] and rB = byte1[3:0]. When it is absent, rA = rB = 4'hF.
- valC, little-endian:
  - If a register byte is present: bytes 2..5.
  - JXX and CALL: bytes 1..4.
  - Otherwise: 0.
- valP = f_pc + length, modulo 2^32 (wraps).
- Predicted PC: valC for JXX and CALL; valP otherwise.
- Status, in priority order: imem_error gives ADR; otherwise invalid gives INS; otherwise HALT gives HLT; otherwise AOK.
- When status is not AOK, the next predicted PC is f_pc, so the stage refetches the same address and stops advancing.
- F/D register, per edge:
  - D_stall: hold.
  - else D_bubble: load the bubble (stat=BUB, icode=NOP, ifun=0, rA=rB=F, valC=valP=0).
  - else: load the fetched fields.
  - D_stall with D_bubble: stall wins.
- F_predPC register: holds when F_stall is set, otherwise loads the new prediction.

## Timing
- Reset (asynchronous, RST_N low):
  - F_predPC = RESET_PC.
  - The F/D register holds a bubble: D_stat=BUB, D_icode=NOP, D_ifun=0, D_rA=D_rB=F, D_valC=D_valP=0.
- The first real fetch appears on D_* one edge after RST_N deasserts.
- imem_addr is combinational from registers and from the M/W inputs, with no cycle delay. Correction paths take effect in the same cycle that M_icode or W_icode is presented.
- Fetch-to-D latency: one cycle.
- F_stall and D_stall are expected together for load-use; each acts independently.
- Reset released mid-stall: reset values apply regardless of stall or bubble.

## Structure
- Shared header, already included:
  - DATA_WID.
  - icode constants HALT..POPL (0x0–0xB).
  - REG_NONE = 4'hF.
  - stat codes BUB=0, AOK=1, HLT=2, ADR=3, INS=4.
- Sub-module: instr_split, combinational. It takes the byte window and produces icode, ifun, rA, rB, valC, length, need_regids, need_valC and instr_valid.
- The top of fetch_stage holds the PC select, predicted-PC register and F/D register.

## Test plan
- Reset: RESET_PC=0x100, RST_N pulsed low mid-cycle. Required: imem_addr=0x100 immediately and D_stat=BUB. After release, with imem_data=30_F2_04_00_00_00 (irmovl $4,%edx), the next edge gives D_icode=3, D_rB=2, D_valC=4, D_valP=0x106.
- Jump prediction: 0x20 holds jXX to 0x80. Required: the next imem_addr is 0x80 and D_valP=0x25. Then M_icode=JXX with M_Cnd=0 and M_valA=0x25. Required: imem_addr=0x25 in the same cycle.
- Ret and mispredict together: W_icode=RET, W_valM=0x44 with no mispredict gives imem_addr=0x44. Adding M mispredict to 0x30 gives imem_addr=0x30.
- Stall and bubble:
  - D_stall for 2 cycles: D_* unchanged and imem_addr unchanged under F_stall.
  - D_bubble alone: D_stat=BUB and D_icode=NOP next edge.
  - D_stall and D_bubble together: hold.
- Errors:
  - imem_error=1 gives D_stat=ADR and D_icode=NOP, and imem_addr stays fixed on subsequent cycles.
  - Byte0=0xC0 gives D_stat=INS.
  - Byte0=0x00 gives D_stat=HLT.
- Wrap: F_predPC=0xFFFF_FFFE with irmovl gives D_valP=0x0000_0004.
